// File: rtl/wb_arb2.sv
// ---------------------------------------------------------------------------
// wb_arb2 -- two-master / one-slave Wishbone arbiter.
//
// Shares a single slave (the SDRAM controller) between the instruction-fetch
// master (m0) and the data master (m1). Arbitration is round-robin and is
// decided only from IDLE. A grant is held for the whole CYC, so multi-beat
// and locked sequences are never split. A watchdog aborts a transfer that
// sees no termination for TIMEOUT stalled cycles and reports ERR to the
// master that owned it.
//
// Bus handshake (classic Wishbone): a beat is offered while CYC and STB are
// both high. It completes on the cycle the slave returns ACK or ERR, and the
// termination is routed only to the granted master. CYC low ends ownership.
//
// Ports:
//   clk_i, rst_n                   clock, synchronous active-low reset
//   m0_* / m1_*                    master-side Wishbone (cyc/stb/we/sel/adr/
//                                  dat in; dat/ack/err out)
//   s_*                            slave-side Wishbone (cyc/stb/we/sel/adr/
//                                  dat out; dat/ack/err in)
//   gnt_o                          one-hot grant (bit n: master n owns slave)
//   dbg_state                      current FSM state, for observation
//
// Parameters:
//   AW, DW   address / data width
//   TIMEOUT  stalled cycles (STB high, no ACK/ERR) before abort, 1..65535
// ---------------------------------------------------------------------------
module wb_arb2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_n,
   // master 0 (instruction fetch)
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   // master 1 (data)
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   // shared slave
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   // status
   output logic [1:0]      gnt_o,
   output logic [1:0]      dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT0  = 2'd1;
   localparam logic [1:0] ST_GNT1  = 2'd2;
   localparam logic [1:0] ST_ABORT = 2'd3;

   // The abort fires on the stalled cycle that would take the count to
   // TIMEOUT, so compare against TIMEOUT-1.
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic        last;      // master that most recently owned the slave
   logic        last_nx;
   logic        owner;     // master of the current (or aborted) grant
   logic        owner_nx;
   logic [15:0] wdog;
   logic [15:0] wdog_nx;

   logic            granted;
   logic            aborting;
   logic            sel_cyc;
   logic            sel_stb;
   logic            sel_we;
   logic [DW/8-1:0] sel_sel;
   logic [AW-1:0]   sel_adr;
   logic [DW-1:0]   sel_dat;
   logic            stall;
   logic            timeout_hit;
   logic            term_ack;
   logic            term_err;

   assign granted  = (state == ST_GNT0) || (state == ST_GNT1);
   assign aborting = (state == ST_ABORT);

   // Owner-selected master signals. owner is only meaningful while granted
   // or aborting; every use below is gated by one of those.
   assign sel_cyc = owner ? m1_cyc_i : m0_cyc_i;
   assign sel_stb = owner ? m1_stb_i : m0_stb_i;
   assign sel_we  = owner ? m1_we_i  : m0_we_i;
   assign sel_sel = owner ? m1_sel_i : m0_sel_i;
   assign sel_adr = owner ? m1_adr_i : m0_adr_i;
   assign sel_dat = owner ? m1_dat_i : m0_dat_i;

   // Slave side: pass the owner straight through, quiet otherwise.
   always_comb begin
      s_cyc_o = granted & sel_cyc;
      s_stb_o = granted & sel_cyc & sel_stb;
      s_we_o  = granted & sel_we;
      s_sel_o = granted ? sel_sel : '0;
      s_adr_o = granted ? sel_adr : '0;
      s_dat_o = granted ? sel_dat : '0;
   end

   // Read data is broadcast; only the owner sees a termination.
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   // Terminations are suppressed while reset is asserted so a transfer that
   // reset cuts short never reports a completion. A slave ack outside a
   // grant (IDLE or ABORT) is dropped.
   assign term_ack = rst_n & granted & s_ack_i;
   assign term_err = rst_n & ((granted & s_err_i) | aborting);

   assign m0_ack_o = term_ack & ~owner;
   assign m0_err_o = term_err & ~owner;
   assign m1_ack_o = term_ack &  owner;
   assign m1_err_o = term_err &  owner;

   // The aborted master keeps its grant bit for the single ABORT cycle.
   assign gnt_o     = (granted | aborting) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign dbg_state = state;

   // A stalled beat: offered to the slave with no termination this cycle.
   // An ack on the cycle the count would expire takes priority.
   assign stall       = s_stb_o & ~s_ack_i & ~s_err_i;
   assign timeout_hit = stall & (wdog == WD_LAST);

   always_comb begin
      state_nx = state;
      last_nx  = last;
      owner_nx = owner;
      wdog_nx  = '0;
      case (state)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               // Tie: the master that did not go last wins.
               owner_nx = ~last;
               state_nx = last ? ST_GNT0 : ST_GNT1;
            end else if (m0_cyc_i) begin
               owner_nx = 1'b0;
               state_nx = ST_GNT0;
            end else if (m1_cyc_i) begin
               owner_nx = 1'b1;
               state_nx = ST_GNT1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (!sel_cyc) begin
               // Release always passes through IDLE: one dead cycle.
               state_nx = ST_IDLE;
               last_nx  = owner;
            end else if (timeout_hit) begin
               state_nx = ST_ABORT;
            end else if (stall) begin
               wdog_nx = wdog + 16'd1;
            end
         end
         ST_ABORT: begin
            state_nx = ST_IDLE;
            last_nx  = owner;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         last  <= 1'b1;  // m0 wins the first tie after reset
         owner <= 1'b0;
         wdog  <= '0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         owner <= owner_nx;
         wdog  <= wdog_nx;
      end
   end

endmodule

// File: tb/tb_wb_arb2.sv
// ---------------------------------------------------------------------------
// Testbench for wb_arb2. The bench plays both masters and the slave.
// Directed scenarios check fixed timing; a randomized phase checks every
// output each cycle against a transaction-level reference model.
// Inputs are driven 1 time unit after the rising edge and outputs sampled
// 3 units after the edge.
// ---------------------------------------------------------------------------
module tb_wb_arb2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GNT0  = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
   logic [DW/8-1:0] m0_sel_i = '0;
   logic [AW-1:0]   m0_adr_i = '0;
   logic [DW-1:0]   m0_dat_i = '0;
   logic [DW-1:0]   m0_dat_o;
   logic            m0_ack_o, m0_err_o;
   logic            m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
   logic [DW/8-1:0] m1_sel_i = '0;
   logic [AW-1:0]   m1_adr_i = '0;
   logic [DW-1:0]   m1_dat_i = '0;
   logic [DW-1:0]   m1_dat_o;
   logic            m1_ack_o, m1_err_o;
   logic            s_cyc_o, s_stb_o, s_we_o;
   logic [DW/8-1:0] s_sel_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [DW-1:0]   s_dat_i = '0;
   logic            s_ack_i = 1'b0, s_err_i = 1'b0;
   logic [1:0]      gnt_o;
   logic [1:0]      dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_n(rst_n),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .gnt_o(gnt_o), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   // Ownership view: m_owner is -1 when nobody holds the slave, else the
   // master number; m_abort marks the one-cycle abort; m_stall counts
   // consecutive stalled beats of the current owner.
   int   m_owner = -1;
   logic m_abort = 1'b0;
   int   m_stall = 0;
   int   m_last  = 1;

   logic            own_cyc, own_stb, own_we;
   logic [DW/8-1:0] own_sel;
   logic [AW-1:0]   own_adr;
   logic [DW-1:0]   own_dat;
   assign own_cyc = (m_owner == 1) ? m1_cyc_i : m0_cyc_i;
   assign own_stb = (m_owner == 1) ? m1_stb_i : m0_stb_i;
   assign own_we  = (m_owner == 1) ? m1_we_i  : m0_we_i;
   assign own_sel = (m_owner == 1) ? m1_sel_i : m0_sel_i;
   assign own_adr = (m_owner == 1) ? m1_adr_i : m0_adr_i;
   assign own_dat = (m_owner == 1) ? m1_dat_i : m0_dat_i;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_abort <= 1'b0;
         m_stall <= 0;
         m_last  <= 1;
      end else if (m_abort) begin
         m_abort <= 1'b0;
         m_last  <= m_owner;
         m_owner <= -1;
         m_stall <= 0;
      end else if (m_owner < 0) begin
         m_stall <= 0;
         if (m0_cyc_i && m1_cyc_i) m_owner <= (m_last == 0) ? 1 : 0;
         else if (m0_cyc_i)        m_owner <= 0;
         else if (m1_cyc_i)        m_owner <= 1;
      end else if (!own_cyc) begin
         m_last  <= m_owner;
         m_owner <= -1;
         m_stall <= 0;
      end else if (own_stb && !s_ack_i && !s_err_i) begin
         if (m_stall + 1 == TO) begin
            m_abort <= 1'b1;
            m_stall <= 0;
         end else begin
            m_stall <= m_stall + 1;
         end
      end else begin
         m_stall <= 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                           input logic [DW/8-1:0] sel, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat);
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
   endtask

   task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                           input logic [DW/8-1:0] sel, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat);
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
   endtask

   task automatic drive_slave(input logic ack, input logic err, input logic [DW-1:0] dat);
      s_ack_i = ack; s_err_i = err; s_dat_i = dat;
   endtask

   task automatic idle_all();
      drive_m0(0, 0, 0, '0, '0, '0);
      drive_m1(0, 0, 0, '0, '0, '0);
      drive_slave(0, 0, '0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [DW-1:0] d;
      idle_all();
      rst_n = 1'b0;
      tick();
      tick();
      d = $urandom;
      drive_m0(1, 1, 0, 4'hF, 32'h100, '0);
      s_dat_i = d;
      #2;
      n_checks++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt_o); else n_pass++;
      n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) $display("FAIL reset_sctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); else n_pass++;
      n_checks++; if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); else n_pass++;
      n_checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) $display("FAIL reset_term: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); else n_pass++;
      n_checks++; if (m0_dat_o !== d || m1_dat_o !== d) $display("FAIL reset_dat: got %h/%h want %h", m0_dat_o, m1_dat_o, d); else n_pass++;
      tick();
      #2;
      n_checks++; if (gnt_o !== 2'b00) $display("FAIL reset_hold_gnt: got %b want 00", gnt_o); else n_pass++;
      idle_all();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_m0_read();
      tick();
      drive_m0(1, 1, 0, 4'hF, 32'h0000_1000, '0);
      #2;
      n_checks++; if (s_cyc_o !== 1'b0) $display("FAIL read_latency_idle: s_cyc got %b want 0", s_cyc_o); else n_pass++;
      tick();
      #2;
      n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b110) $display("FAIL read_sctl: got %b want 110", {s_cyc_o, s_stb_o, s_we_o}); else n_pass++;
      n_checks++; if (s_adr_o !== 32'h0000_1000) $display("FAIL read_adr: got %h want 00001000", s_adr_o); else n_pass++;
      n_checks++; if (gnt_o !== 2'b01) $display("FAIL read_gnt: got %b want 01", gnt_o); else n_pass++;
      for (int k = 1; k <= 2; k++) begin
         tick();
         #2;
         n_checks++; if (m0_ack_o !== 1'b0) $display("FAIL read_wait_ack%0d: got %b want 0", k, m0_ack_o); else n_pass++;
      end
      tick();
      drive_slave(1, 0, 32'hDEAD_BEEF);
      #2;
      n_checks++; if (m0_ack_o !== 1'b1) $display("FAIL read_ack: got %b want 1", m0_ack_o); else n_pass++;
      n_checks++; if (m0_dat_o !== 32'hDEAD_BEEF) $display("FAIL read_data: got %h want deadbeef", m0_dat_o); else n_pass++;
      n_checks++; if (m1_ack_o !== 1'b0) $display("FAIL read_m1_ack: got %b want 0", m1_ack_o); else n_pass++;
      n_checks++; if (gnt_o !== 2'b01) $display("FAIL read_gnt_ack: got %b want 01", gnt_o); else n_pass++;
      tick();
      idle_all();
      #2;
      n_checks++; if (m0_ack_o !== 1'b0) $display("FAIL read_ack_drop: got %b want 0", m0_ack_o); else n_pass++;
      tick();
      #2;
      n_checks++; if (gnt_o !== 2'b00) $display("FAIL read_release: got %b want 00", gnt_o); else n_pass++;
   endtask

   task automatic test_tie();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive_m0(1, 1, 0, 4'hF, 32'h2000, '0);
      drive_m1(1, 1, 1, 4'hF, 32'h3000, $urandom);
      #2;
      n_checks++; if (gnt_o !== 2'b00) $display("FAIL tie_idle: got %b want 00", gnt_o); else n_pass++;
      tick();
      drive_slave(1, 0, $urandom);
      #2;
      n_checks++; if (gnt_o !== 2'b01) $display("FAIL tie_first_m0: got %b want 01", gnt_o); else n_pass++;
      n_checks++; if (s_adr_o !== 32'h2000) $display("FAIL tie_adr_m0: got %h want 00002000", s_adr_o); else n_pass++;
      n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) $display("FAIL tie_ack_m0: got %b want 10", {m0_ack_o, m1_ack_o}); else n_pass++;
      tick();
      drive_m0(0, 0, 0, '0, '0, '0);
      drive_slave(0, 0, '0);
      #2;
      n_checks++; if ({gnt_o, s_cyc_o} !== 3'b010) $display("FAIL tie_drop: got %b want 010", {gnt_o, s_cyc_o}); else n_pass++;
      tick();
      #2;
      n_checks++; if (gnt_o !== 2'b00) $display("FAIL tie_dead_cycle: got %b want 00", gnt_o); else n_pass++;
      tick();
      drive_slave(1, 0, $urandom);
      #2;
      n_checks++; if (gnt_o !== 2'b10) $display("FAIL tie_second_m1: got %b want 10", gnt_o); else n_pass++;
      n_checks++; if ({s_adr_o, s_we_o} !== {32'h3000, 1'b1}) $display("FAIL tie_adr_m1: got %h/%b want 00003000/1", s_adr_o, s_we_o); else n_pass++;
      n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b01) $display("FAIL tie_ack_m1: got %b want 01", {m0_ack_o, m1_ack_o}); else n_pass++;
      tick();
      drive_slave(0, 0, '0);
      drive_m1(0, 0, 0, '0, '0, '0);
      drive_m0(1, 1, 0, 4'hF, 32'h2004, '0);
      #2;
      tick();
      drive_m1(1, 1, 0, 4'hF, 32'h3004, '0);
      #2;
      n_checks++; if (gnt_o !== 2'b00) $display("FAIL tie2_idle: got %b want 00", gnt_o); else n_pass++;
      tick();
      #2;
      n_checks++; if (gnt_o !== 2'b01) $display("FAIL tie2_m0: got %b want 01", gnt_o); else n_pass++;
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0]    sels[4];
      logic [AW-1:0] adrs[4];
      logic [DW-1:0] dats[4];
      sels = '{4'b1111, 4'b0011, 4'b1111, 4'b0011};
      for (int b = 0; b < 4; b++) begin
         adrs[b] = 32'h0000_8000 + 32'(b * 4);
         dats[b] = $urandom;
      end
      tick();
      drive_m1(1, 1, 1, sels[0], adrs[0], dats[0]);
      for (int b = 0; b < 4; b++) begin
         tick();
         drive_m1(1, 1, 1, sels[b], adrs[b], dats[b]);
         drive_m0(1, 1, 0, 4'hF, 32'h4000, '0);
         drive_slave(1, 0, '0);
         #2;
         n_checks++; if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== {adrs[b], dats[b], sels[b], 1'b1})
            $display("FAIL burst_beat%0d: got %h/%h/%b/%b want %h/%h/%b/1", b, s_adr_o, s_dat_o, s_sel_o, s_we_o, adrs[b], dats[b], sels[b]);
         else n_pass++;
         n_checks++; if ({gnt_o, m1_ack_o, m0_ack_o} !== 4'b1010) $display("FAIL burst_owner%0d: got %b want 1010", b, {gnt_o, m1_ack_o, m0_ack_o}); else n_pass++;
      end
      tick();
      drive_m1(0, 0, 0, '0, '0, '0);
      drive_slave(0, 0, '0);
      #2;
      n_checks++; if (gnt_o !== 2'b10) $display("FAIL burst_drop: got %b want 10", gnt_o); else n_pass++;
      tick();
      #2;
      n_checks++; if (gnt_o !== 2'b00) $display("FAIL burst_dead: got %b want 00", gnt_o); else n_pass++;
      tick();
      drive_slave(1, 0, '0);
      #2;
      n_checks++; if ({gnt_o, s_adr_o, m0_ack_o} !== {2'b01, 32'h4000, 1'b1}) $display("FAIL burst_m0_next: got %b/%h/%b want 01/00004000/1", gnt_o, s_adr_o, m0_ack_o); else n_pass++;
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_timeout();
      tick();
      drive_m0(1, 1, 0, 4'hF, 32'h5000, '0);
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (k == 2) drive_m1(1, 1, 0, 4'hF, 32'h6000, '0);
         #2;
         n_checks++; if ({gnt_o, m0_err_o, dbg_state} !== {2'b01, 1'b0, S_GNT0}) $display("FAIL to_stall%0d: got %b want 01_0_%b", k, {gnt_o, m0_err_o, dbg_state}, S_GNT0); else n_pass++;
      end
      tick();
      drive_slave(1, 0, '0);
      #2;
      n_checks++; if (dbg_state !== S_ABORT) $display("FAIL to_abort_state: got %0d want %0d", dbg_state, S_ABORT); else n_pass++;
      n_checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) $display("FAIL to_abort_scyc: got %b want 00", {s_cyc_o, s_stb_o}); else n_pass++;
      n_checks++; if ({m0_err_o, m0_ack_o, m1_err_o, m1_ack_o} !== 4'b1000) $display("FAIL to_abort_term: got %b want 1000", {m0_err_o, m0_ack_o, m1_err_o, m1_ack_o}); else n_pass++;
      n_checks++; if (gnt_o !== 2'b01) $display("FAIL to_abort_gnt: got %b want 01", gnt_o); else n_pass++;
      tick();
      drive_slave(0, 0, '0);
      #2;
      n_checks++; if ({dbg_state, gnt_o, m0_err_o} !== {S_IDLE, 2'b00, 1'b0}) $display("FAIL to_idle: got %b want %b_00_0", {dbg_state, gnt_o, m0_err_o}, S_IDLE); else n_pass++;
      tick();
      drive_slave(1, 0, '0);
      #2;
      n_checks++; if ({gnt_o, m1_ack_o} !== 3'b101) $display("FAIL to_m1_next: got %b want 101", {gnt_o, m1_ack_o}); else n_pass++;
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_ack_at_timeout();
      tick();
      drive_m0(1, 1, 0, 4'hF, 32'h7000, '0);
      for (int k = 1; k < TO; k++) begin
         tick();
         #2;
         n_checks++; if ({gnt_o, m0_err_o} !== 3'b010) $display("FAIL acktmo_stall%0d: got %b want 010", k, {gnt_o, m0_err_o}); else n_pass++;
      end
      tick();
      drive_slave(1, 0, 32'hCAFE_F00D);
      #2;
      n_checks++; if ({m0_ack_o, m0_err_o} !== 2'b10) $display("FAIL acktmo_ack: got %b want 10", {m0_ack_o, m0_err_o}); else n_pass++;
      n_checks++; if (m0_dat_o !== 32'hCAFE_F00D) $display("FAIL acktmo_data: got %h want cafef00d", m0_dat_o); else n_pass++;
      tick();
      drive_slave(0, 0, '0);
      #2;
      n_checks++; if ({dbg_state, gnt_o} !== {S_GNT0, 2'b01}) $display("FAIL acktmo_stay: got %b want %b_01", {dbg_state, gnt_o}, S_GNT0); else n_pass++;
      // The count restarted on the ack, so a full TIMEOUT of new stalls
      // is needed before the next abort.
      for (int k = 2; k <= TO; k++) begin
         tick();
         #2;
         n_checks++; if ({dbg_state, m0_err_o} !== {S_GNT0, 1'b0}) $display("FAIL acktmo_restall%0d: got %b want %b_0", k, {dbg_state, m0_err_o}, S_GNT0); else n_pass++;
      end
      tick();
      #2;
      n_checks++; if ({dbg_state, m0_err_o} !== {S_ABORT, 1'b1}) $display("FAIL acktmo_abort: got %b want %b_1", {dbg_state, m0_err_o}, S_ABORT); else n_pass++;
      tick();
      idle_all();
      #2;
      n_checks++; if (dbg_state !== S_IDLE) $display("FAIL acktmo_idle: got %0d want %0d", dbg_state, S_IDLE); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      tick();
      drive_m1(1, 1, 0, 4'hF, 32'h9000, '0);
      tick();
      #2;
      n_checks++; if (gnt_o !== 2'b10) $display("FAIL rstmid_gnt: got %b want 10", gnt_o); else n_pass++;
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      n_checks++; if ({m1_ack_o, m1_err_o} !== 2'b00) $display("FAIL rstmid_term_during: got %b want 00", {m1_ack_o, m1_err_o}); else n_pass++;
      tick();
      rst_n = 1'b1;
      drive_m0(1, 1, 0, 4'hF, 32'hA000, '0);
      #2;
      n_checks++; if ({s_cyc_o, gnt_o} !== 3'b000) $display("FAIL rstmid_drop: got %b want 000", {s_cyc_o, gnt_o}); else n_pass++;
      n_checks++; if ({m1_ack_o, m1_err_o} !== 2'b00) $display("FAIL rstmid_term_after: got %b want 00", {m1_ack_o, m1_err_o}); else n_pass++;
      tick();
      #2;
      n_checks++; if (gnt_o !== 2'b01) $display("FAIL rstmid_tie_m0: got %b want 01", gnt_o); else n_pass++;
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_random(input int n);
      logic            c0 = 1'b0;
      logic            c1 = 1'b0;
      logic            gr;
      logic [1:0]      e_gnt;
      logic [8:0]      e_ctl;
      logic [8:0]      a_ctl;
      logic            e0a, e0e, e1a, e1e;
      int              ack_pct;
      for (int i = 0; i < n; i++) begin
         tick();
         if (!c0) c0 = ($urandom_range(0, 3) == 0); else if ($urandom_range(0, 7) == 0) c0 = 1'b0;
         if (!c1) c1 = ($urandom_range(0, 3) == 0); else if ($urandom_range(0, 7) == 0) c1 = 1'b0;
         drive_m0(c0, c0 & ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), $urandom, $urandom);
         drive_m1(c1, c1 & ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), $urandom, $urandom);
         ack_pct = (i < n / 2) ? 50 : 8;
         drive_slave($urandom_range(0, 99) < ack_pct, $urandom_range(0, 24) == 0, $urandom);
         rst_n = ($urandom_range(0, 149) != 0);
         #2;
         gr    = (m_owner >= 0) && !m_abort;
         e_gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
         e0a   = rst_n && gr && (m_owner == 0) && s_ack_i;
         e1a   = rst_n && gr && (m_owner == 1) && s_ack_i;
         e0e   = rst_n && (m_owner == 0) && (m_abort || (gr && s_err_i));
         e1e   = rst_n && (m_owner == 1) && (m_abort || (gr && s_err_i));
         e_ctl = {e_gnt, gr && own_cyc, gr && own_cyc && own_stb, gr && own_we, e0a, e0e, e1a, e1e};
         a_ctl = {gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
         n_checks++; if (a_ctl !== e_ctl) $display("FAIL rand_ctl@%0d: got %b want %b", i, a_ctl, e_ctl); else n_pass++;
         n_checks++; if (s_adr_o !== (gr ? own_adr : '0)) $display("FAIL rand_adr@%0d: got %h want %h", i, s_adr_o, gr ? own_adr : '0); else n_pass++;
         n_checks++; if (s_dat_o !== (gr ? own_dat : '0)) $display("FAIL rand_dat@%0d: got %h want %h", i, s_dat_o, gr ? own_dat : '0); else n_pass++;
         n_checks++; if (s_sel_o !== (gr ? own_sel : '0)) $display("FAIL rand_sel@%0d: got %b want %b", i, s_sel_o, gr ? own_sel : '0); else n_pass++;
         n_checks++; if (m0_dat_o !== s_dat_i || m1_dat_o !== s_dat_i) $display("FAIL rand_rdat@%0d: got %h/%h want %h", i, m0_dat_o, m1_dat_o, s_dat_i); else n_pass++;
      end
      tick();
      rst_n = 1'b1;
      idle_all();
      tick();
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_m0_read();
      test_tie();
      test_back_to_back();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid();
      test_random(600);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
